game_flow_ctrl: RTL and testbench

Parametrised game-flow controller for the dino runner. It sequences IDLE/PLAY/OVER and an optional PAUSE state, detects pixel-level collisions between the dino and N obstacle channels, and ramps scroll speed on frame boundaries. It also keeps a per-frame score and supports restart from OVER after a hold-off. It sits between the key debouncer and the sprite/scroll engines, entirely in the lcd_pclk domain.

---
 rtl/game_pkg.sv | 19 +
 rtl/game_flow_ctrl_if.sv | 34 +++
 rtl/game_speed_ramp.sv | 53 +++++
 rtl/game_flow_ctrl.sv | 138 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the dino runner game-flow controller.
// States, default speed constants and the hit-index width helper.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_e;

    localparam int RATE_INIT_DEF = 4;
    localparam int RATE_MAX_DEF  = 10;

    function automatic int hit_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Key/pixel inputs and speed/score/status outputs of the game-flow controller.
// The master drives the inputs; the controller is the slave.
interface game_flow_ctrl_if #(
    parameter int N_OBST  = 2,
    parameter int RATE_W  = 4,
    parameter int SCORE_W = 16,
    parameter int HIT_W   = 1
);
    logic                start_req;
    logic                pause_req;
    logic                frame_tick;
    logic                dino_draw;
    logic [N_OBST-1:0]   obst_draw;
    logic [RATE_W-1:0]   move_rate;
    logic [SCORE_W-1:0]  score;
    logic [HIT_W-1:0]    hit_idx;
    logic                is_living;
    logic                is_paused;
    logic                is_dying;

    modport master (
        output start_req, pause_req, frame_tick,
        output dino_draw, obst_draw,
        input  move_rate, score, hit_idx,
        input  is_living, is_paused, is_dying
    );

    modport slave (
        input  start_req, pause_req, frame_tick,
        input  dino_draw, obst_draw,
        output move_rate, score, hit_idx,
        output is_living, is_paused, is_dying
    );
endinterface

// File: rtl/game_speed_ramp.sv
// Frame-counted scroll speed ramp with saturating move_rate.
// init_i reloads the start speed; en_i gates counting to live play frames.
module game_speed_ramp #(
    parameter int RATE_W      = 4,
    parameter int RATE_INIT   = 4,
    parameter int RATE_MAX    = 10,
    parameter int RAMP_FRAMES = 120
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic              init_i,
    input  logic              en_i,
    input  logic              frame_tick_i,
    output logic [RATE_W-1:0] move_rate_o
);
    localparam int CNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              at_max;
    logic              wrap;

    assign at_max = (rate_q >= RATE_W'(RATE_MAX));
    assign wrap   = (cnt_q == CNT_W'(RAMP_FRAMES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        rate_d = rate_q;
        if (init_i) begin
            cnt_d  = '0;
            rate_d = RATE_W'(RATE_INIT);
        end else if (en_i && frame_tick_i && !at_max) begin
            if (wrap) begin
                cnt_d  = '0;
                rate_d = rate_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rate_q <= RATE_W'(RATE_INIT);
        end else begin
            cnt_q  <= cnt_d;
            rate_q <= rate_d;
        end
    end

    assign move_rate_o = rate_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// Dino runner game-flow controller: IDLE/PLAY/OVER (+PAUSE), collision, score.
// Optional PAUSE state is built when GAME_PAUSE_EN is defined.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int N_OBST         = 2,
    parameter int RATE_W         = 4,
    parameter int RATE_INIT      = RATE_INIT_DEF,
    parameter int RATE_MAX       = RATE_MAX_DEF,
    parameter int RAMP_FRAMES    = 120,
    parameter int SCORE_W        = 16,
    parameter int HOLDOFF_FRAMES = 60
) (
    input  logic             lcd_pclk,
    input  logic             rst_n,
    game_flow_ctrl_if.slave  bus
);
    localparam int HIT_W  = hit_width(N_OBST);
    localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ?
                            $clog2(HOLDOFF_FRAMES + 1) : 1;

    function automatic logic [HIT_W-1:0] lowest_set(
        input logic [N_OBST-1:0] v
    );
        logic [HIT_W-1:0] idx;
        idx = '0;
        for (int i = N_OBST - 1; i >= 0; i--) begin
            if (v[i]) idx = HIT_W'(i);
        end
        return idx;
    endfunction

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [HIT_W-1:0]   hit_q, hit_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               collide;
    logic               pause_hit;
    logic               hold_done;
    logic               run_en;
    logic               init;

    assign collide   = bus.dino_draw & (|bus.obst_draw);
    assign hold_done = (hold_q == HOLD_W'(HOLDOFF_FRAMES));

`ifdef GAME_PAUSE_EN
    assign pause_hit = bus.pause_req;
`else
    logic unused_pause;
    assign unused_pause = bus.pause_req;
    assign pause_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hit_d   = hit_q;
        hold_d  = hold_q;
        run_en  = 1'b0;
        init    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_req) begin
                    state_d = PLAY;
                    score_d = '0;
                    init    = 1'b1;
                end
            end
            PLAY: begin
                // collision outranks pause, pause outranks frame_tick
                if (collide) begin
                    state_d = OVER;
                    hit_d   = lowest_set(bus.obst_draw
                                         & {N_OBST{bus.dino_draw}});
                    hold_d  = '0;
                end else if (pause_hit) begin
                    state_d = PAUSE;
                end else begin
                    run_en = 1'b1;
                    if (bus.frame_tick && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (pause_hit) state_d = PLAY;
            end
            OVER: begin
                if (bus.start_req && hold_done) begin
                    state_d = PLAY;
                    score_d = '0;
                    init    = 1'b1;
                end else if (bus.frame_tick && !hold_done) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            score_q <= '0;
            hit_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            hold_q  <= hold_d;
        end
    end

    game_speed_ramp #(
        .RATE_W      (RATE_W),
        .RATE_INIT   (RATE_INIT),
        .RATE_MAX    (RATE_MAX),
        .RAMP_FRAMES (RAMP_FRAMES)
    ) u_ramp (
        .lcd_pclk     (lcd_pclk),
        .rst_n        (rst_n),
        .init_i       (init),
        .en_i         (run_en),
        .frame_tick_i (bus.frame_tick),
        .move_rate_o  (bus.move_rate)
    );

    assign bus.score     = score_q;
    assign bus.hit_idx   = hit_q;
    assign bus.is_living = (state_q == PLAY);
    assign bus.is_dying  = (state_q == OVER);
`ifdef GAME_PAUSE_EN
    assign bus.is_paused = (state_q == PAUSE);
`else
    assign bus.is_paused = 1'b0;
`endif
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed steps queue expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int N_OBST  = 2;
    localparam int RATE_W  = 4;
    localparam int SCORE_W = 16;
    localparam int HIT_W   = hit_width(N_OBST);

    logic lcd_pclk = 1'b0;
    logic rst_n;

    game_flow_ctrl_if #(
        .N_OBST  (N_OBST),
        .RATE_W  (RATE_W),
        .SCORE_W (SCORE_W),
        .HIT_W   (HIT_W)
    ) bus ();

    game_flow_ctrl #(
        .N_OBST         (N_OBST),
        .RATE_W         (RATE_W),
        .RATE_INIT      (4),
        .RATE_MAX       (10),
        .RAMP_FRAMES    (2),
        .SCORE_W        (SCORE_W),
        .HOLDOFF_FRAMES (3)
    ) dut (
        .lcd_pclk (lcd_pclk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    typedef struct {
        string              name;
        logic               liv;
        logic               pau;
        logic               dy;
        logic [SCORE_W-1:0] sc;
        logic [RATE_W-1:0]  rt;
        logic [HIT_W-1:0]   hit;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge lcd_pclk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.is_living !== e.liv || bus.is_paused !== e.pau ||
                bus.is_dying !== e.dy || bus.score !== e.sc ||
                bus.move_rate !== e.rt || bus.hit_idx !== e.hit) begin
                errors++;
                $display("FAIL %s: got liv=%b pau=%b dy=%b sc=%0d rt=%0d hit=%0d exp liv=%b pau=%b dy=%b sc=%0d rt=%0d hit=%0d",
                         e.name, bus.is_living, bus.is_paused,
                         bus.is_dying, bus.score, bus.move_rate,
                         bus.hit_idx, e.liv, e.pau, e.dy, e.sc,
                         e.rt, e.hit);
            end
        end
    end

    task automatic chk(input string n, input logic liv, input logic pau,
                       input logic dy, input int sc, input int rt,
                       input int hit);
        exp_t x;
        x.name = n;
        x.liv  = liv;
        x.pau  = pau;
        x.dy   = dy;
        x.sc   = SCORE_W'(sc);
        x.rt   = RATE_W'(rt);
        x.hit  = HIT_W'(hit);
        q.push_back(x);
    endtask

    task automatic step(input logic s, input logic p, input logic f,
                        input logic d, input logic [N_OBST-1:0] o);
        bus.start_req  = s;
        bus.pause_req  = p;
        bus.frame_tick = f;
        bus.dino_draw  = d;
        bus.obst_draw  = o;
        @(posedge lcd_pclk);
        #1;
        bus.start_req  = 1'b0;
        bus.pause_req  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.dino_draw  = 1'b0;
        bus.obst_draw  = '0;
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start_req  = 1'b0;
        bus.pause_req  = 1'b0;
        bus.frame_tick = 1'b0;
        bus.dino_draw  = 1'b0;
        bus.obst_draw  = '0;
        repeat (2) @(posedge lcd_pclk);
        #1;
        chk("reset", 0, 0, 0, 0, 4, 0);
        @(negedge lcd_pclk);
        rst_n = 1'b1;
        @(posedge lcd_pclk);
        #1;

        tick();
        chk("idle_tick", 0, 0, 0, 0, 4, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("start", 1, 0, 0, 0, 4, 0);
        tick();
        chk("tick1", 1, 0, 0, 1, 4, 0);
        tick();
        chk("tick2", 1, 0, 0, 2, 5, 0);
        tick();
        chk("tick3", 1, 0, 0, 3, 5, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("start_in_play", 1, 0, 0, 3, 5, 0);
        repeat (9) tick();
        chk("ramp_reach_max", 1, 0, 0, 12, 10, 0);
        repeat (8) tick();
        chk("ramp_hold_max", 1, 0, 0, 20, 10, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        chk("obst_no_dino", 1, 0, 0, 21, 10, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        chk("collide_11", 0, 0, 1, 21, 10, 0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("over_start_0", 0, 0, 1, 21, 10, 0);
        tick();
        tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("over_start_2", 0, 0, 1, 21, 10, 0);
        tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("restart", 1, 0, 0, 0, 4, 0);
        tick();
        chk("restart_tick", 1, 0, 0, 1, 4, 0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
`ifdef GAME_PAUSE_EN
        chk("pause", 0, 1, 0, 1, 4, 0);
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
        chk("pause_frozen", 0, 1, 0, 1, 4, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("resume", 1, 0, 0, 1, 4, 0);
`else
        chk("pause_ignored", 1, 0, 0, 1, 4, 0);
        repeat (5) tick();
        chk("nopause_score", 1, 0, 0, 6, 7, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("pause_ignored2", 1, 0, 0, 6, 7, 0);
`endif

        @(posedge lcd_pclk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, 0, 0, 0, 4, 0);
        @(negedge lcd_pclk);
        #1;
        rst_n = 1'b1;
        @(posedge lcd_pclk);
        #1;

        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("start_after_rst", 1, 0, 0, 0, 4, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        chk("collide_10", 0, 0, 1, 0, 4, 1);

        repeat (2) @(negedge lcd_pclk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending, exp 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
